// File: rtl/lp_decimator.sv
// Purpose: keeps one FIR output sample in every M (runtime factor, sync re-phase) into a 2-entry skid buffer.
// Latency: a kept sample is on y_data one cycle after acceptance when the output path is free.
// Backpressure: x_ready = skid empty; while stalled no input is taken, so the phase holds too.
module lp_decimator #(
    parameter int W     = 32,
    parameter int MAX_M = 16,
    parameter int CW    = $clog2(MAX_M + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] factor,
    input  logic          sync,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic [W-1:0]  x_data,
    output logic          y_valid,
    input  logic          y_ready,
    output logic [W-1:0]  y_data,
    output logic [CW-1:0] m_active
);

    logic [CW-1:0] phase;
    logic [CW-1:0] phase_nxt;
    logic [CW-1:0] m_clamped;
    logic          sync_pend;
    logic          skid_vld;
    logic [W-1:0]  skid_dat;
    logic          accept;
    logic          keep;
    logic          out_free;

    // 0 and 1 both mean pass-through; oversize requests saturate.
    always_comb begin
        m_clamped = factor;
        if (factor == '0) begin
            m_clamped = CW'(1);
        end else if (factor > CW'(MAX_M)) begin
            m_clamped = CW'(MAX_M);
        end
    end

    assign accept   = x_valid & x_ready;
    assign keep     = accept & (sync | sync_pend | (phase == '0));
    assign out_free = ~y_valid | y_ready;

    // A kept sample is phase 0 of the frame governed by the factor it latches.
    always_comb begin
        phase_nxt = phase;
        if (keep) begin
            phase_nxt = (m_clamped == CW'(1)) ? '0 : CW'(1);
        end else if (accept) begin
            phase_nxt = (phase + CW'(1) == m_active) ? '0 : phase + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase     <= '0;
            m_active  <= CW'(1);
            sync_pend <= 1'b0;
        end else begin
            phase <= phase_nxt;
            if (keep) begin
                m_active <= m_clamped;
            end
            if (accept) begin
                sync_pend <= 1'b0;
            end else if (sync) begin
                sync_pend <= 1'b1;
            end
        end
    end

    // Skid is only ever written while x_ready is high, i.e. while it is empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_valid  <= 1'b0;
            y_data   <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
            x_ready  <= 1'b1;
        end else if (out_free) begin
            if (skid_vld) begin
                y_valid  <= 1'b1;
                y_data   <= skid_dat;
                skid_vld <= 1'b0;
                x_ready  <= 1'b1;
            end else if (keep) begin
                y_valid <= 1'b1;
                y_data  <= x_data;
            end else begin
                y_valid <= 1'b0;
            end
        end else if (keep) begin
            skid_vld <= 1'b1;
            skid_dat <= x_data;
            x_ready  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lp_decimator.sv
// Directed bench for lp_decimator: hand-computed kept-sample sequences, stall and reset behaviour.
module tb_lp_decimator;

    localparam int W     = 32;
    localparam int MAX_M = 16;
    localparam int CW    = $clog2(MAX_M + 1);

    logic          clk;
    logic          reset;
    logic [CW-1:0] factor;
    logic          sync;
    logic          x_valid;
    logic          x_ready;
    logic [W-1:0]  x_data;
    logic          y_valid;
    logic          y_ready;
    logic [W-1:0]  y_data;
    logic [CW-1:0] m_active;

    int vectors;
    int miscompares;
    int stalls;
    logic [W-1:0] got_q[$];
    logic [W-1:0] exp_q[$];

    lp_decimator #(.W(W), .MAX_M(MAX_M), .CW(CW)) dut (
        .clk(clk), .reset(reset), .factor(factor), .sync(sync),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
        .m_active(m_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every output transfer; inputs only change just after posedge.
    always @(negedge clk) begin
        if (!reset && y_valid && y_ready) got_q.push_back(y_data);
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold a sample until accepted; x_valid is left high for back-to-back streams.
    task automatic push(input logic [W-1:0] v);
        bit done;
        done    = 0;
        x_valid = 1'b1;
        x_data  = v;
        for (int i = 0; i < 50 && !done; i++) begin
            if (x_ready) done = 1;
            else stalls++;
            @(posedge clk);
            #1;
        end
        if (!done) chk("push_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        x_valid = 1'b0;
        step(n);
    endtask

    task automatic do_reset(input logic [CW-1:0] f);
        x_valid = 1'b0;
        sync    = 1'b0;
        factor  = f;
        y_ready = 1'b1;
        reset   = 1'b1;
        step(1);
        reset   = 1'b0;
        got_q   = {};
        stalls  = 0;
    endtask

    task automatic chk_q(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk(tag, got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        x_data      = '0;
        do_reset(4);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_data", y_data, 0);
        chk("rst_x_ready", x_ready, 1);
        chk("rst_m_active", m_active, 1);

        // factor 4, full throughput
        push(0);
        chk("t1_lat_valid", y_valid, 1);
        chk("t1_lat_data", y_data, 0);
        chk("t1_m_active", m_active, 4);
        for (int v = 1; v < 12; v++) begin
            push(v);
            if (v == 4) chk("t1_lat4", y_data, 4);
        end
        idle(3);
        chk("t1_no_stall", stalls, 0);
        exp_q = '{0, 4, 8};
        chk_q("t1_out");

        // factor 2 with downstream stalled
        do_reset(2);
        y_ready = 1'b0;
        push(0);
        push(1);
        push(2);
        chk("t2_x_ready_low", x_ready, 0);
        x_data = 3;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t2_hold_valid", y_valid, 1);
            chk("t2_hold_data", y_data, 0);
            chk("t2_no_accept", x_ready, 0);
        end
        y_ready = 1'b1;
        for (int v = 3; v < 8; v++) push(v);
        idle(4);
        exp_q = '{0, 2, 4, 6};
        chk_q("t2_out");

        // factor change mid-frame
        do_reset(3);
        push(0);
        push(1);
        factor = 5;
        push(2);
        chk("t3_m_old", m_active, 3);
        push(3);
        chk("t3_m_new", m_active, 5);
        for (int v = 4; v < 16; v++) push(v);
        idle(3);
        exp_q = '{0, 3, 8, 13};
        chk_q("t3_out");

        // sync realignment
        do_reset(4);
        for (int v = 0; v < 6; v++) push(v);
        sync = 1'b1;
        push(6);
        sync = 1'b0;
        for (int v = 7; v < 12; v++) push(v);
        x_valid = 1'b0;
        sync    = 1'b1;
        step(1);
        sync    = 1'b0;
        push(12);
        push(13);
        idle(3);
        exp_q = '{0, 4, 6, 10, 12};
        chk_q("t4_out");

        // pass-through and clamp
        do_reset(0);
        for (int v = 0; v < 5; v++) push(v);
        idle(3);
        chk("t5_m_pass", m_active, 1);
        exp_q = '{0, 1, 2, 3, 4};
        chk_q("t5_pass");
        do_reset(20);
        for (int v = 0; v < 34; v++) push(v);
        idle(3);
        chk("t5_m_clamp", m_active, 16);
        exp_q = '{0, 16, 32};
        chk_q("t5_clamp");

        // asynchronous reset with skid full
        do_reset(2);
        y_ready = 1'b0;
        push(0);
        push(1);
        push(2);
        x_valid = 1'b0;
        chk("t6_pre_x_ready", x_ready, 0);
        #3 reset = 1'b1;
        #1;
        chk("t6_rst_y_valid", y_valid, 0);
        chk("t6_rst_x_ready", x_ready, 1);
        chk("t6_rst_m_active", m_active, 1);
        step(1);
        reset   = 1'b0;
        y_ready = 1'b1;
        got_q   = {};
        push(32'h1234);
        chk("t6_first_valid", y_valid, 1);
        chk("t6_first_data", y_data, 32'h1234);
        idle(3);
        exp_q = '{32'h1234};
        chk_q("t6_out");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lp_decimator.md
Name: lp_decimator

Overview:
- Stream decimator directly downstream of the 41-tap low-pass FIR in the audio chain. Consumes band-limited FIR output samples and keeps one sample in every M.
- Forwards kept samples through a 2-entry skid buffer with valid/ready handshake on both sides.
- M is runtime-programmable. Phase can be re-aligned by a sync pulse so multiple channels stay coherent.

Parameters:
- W, 32: sample width in bits; samples pass through unmodified (signed fixed-point, format irrelevant here).
- MAX_M, 16: largest supported decimation factor.
- CW, $clog2(MAX_M+1): width of the factor port and phase counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- factor  in  CW  requested decimation factor; 0 and 1 mean pass-through; values above MAX_M clamp to MAX_M.
- sync  in  1  single-cycle pulse; the next accepted input is phase 0.
- x_valid  in  1  upstream sample valid.
- x_ready  out  1  block can accept a sample.
- x_data  in  W  upstream sample.
- y_valid  out  1  output sample valid.
- y_ready  in  1  downstream can accept.
- y_data  out  W  decimated sample.
- m_active  out  CW  factor currently in force, for debug and status.

Behaviour:
- Clocking and reset: one clock domain; reset is asynchronous, active-high.
- Reset values:
  - y_valid=0, y_data=0, x_ready=1, m_active=1.
  - Phase counter = 0, skid register empty, sync-pending flag = 0.
- Acceptance: an input transfer occurs when x_valid & x_ready.
- Phase counter:
  - Advances once per accepted input: 0..m_active-1, then wraps to 0.
  - The accepted sample at phase 0 is kept. All other accepted samples are consumed and discarded; they never stall on downstream.
- Factor latch:
  - On every accepted phase-0 sample, m_active <= clamp(factor).
  - The new factor governs the samples that follow that kept sample.
  - A factor change mid-frame therefore takes effect only at the next kept sample.
- Sync:
  - A sync pulse sets sync-pending.
  - The next accepted sample is forced to phase 0: it is kept and latches the factor.
  - Sync-pending is then cleared.
  - If sync and an input transfer coincide, that same sample is phase 0 and no pending flag remains.
- Output stage (skid buffer):
  - Output register (y_valid/y_data) plus one skid register.
  - A kept sample goes to the output register if it is empty or being drained this cycle (y_valid & y_ready). Otherwise it goes to the skid register.
  - When the output register drains and the skid is full, the skid moves into the output register on the same edge.
  - x_ready is registered and equals "skid empty"; it drops the cycle after the skid fills.
  - Skid-full with output blocked means no input is accepted, including discard-phase samples. Phase therefore never advances while stalled.
- Latency and throughput:
  - Kept sample appears on y_data one cycle after acceptance when the output path is free.
  - Full throughput of 1 input/cycle with y_ready held high.
- Handshake rules:
  - y_data and y_valid are stable while y_valid & ~y_ready.
  - No sample is lost or duplicated under any backpressure pattern.
- Pass-through: with m_active=1 every accepted sample is kept; the block is a pure 2-deep skid buffer.
- Reset mid-operation: pending outputs and skid contents are dropped, phase returns to 0, m_active returns to 1. The first post-reset accepted sample is kept.

Test Plan:
- factor=4, y_ready=1, stream x_data=0..11 back-to-back -> y_data sequence 0,4,8; each appears one cycle after its acceptance; x_ready stays 1 throughout.
- factor=2, y_ready=0 for 6 cycles while feeding 0..7 -> output holds 0; skid holds 2; x_ready falls after sample 2 is accepted and sample 3 is not accepted. Release y_ready -> outputs 0,2,4,6 with no loss and y_data stable while stalled.
- factor=3, change factor to 5 after input 1 -> kept samples 0,3,8,13 (new factor applies from kept sample 3); m_active reads 3 then 5.
- factor=4, pulse sync together with input 6 after inputs 0..5 -> kept 0,4,6,10; pulse sync alone before input 12 -> 12 kept.
- factor=0 -> every sample forwarded. factor=20 -> m_active=16 and samples 0,16,32 kept.
- Assert reset asynchronously mid-frame with output stalled and skid full -> y_valid=0, x_ready=1, m_active=1 immediately. Next accepted sample (value 0x1234) is output.
